// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush controller
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic {
        RUN    = 1'b0,
        MULDIV = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic en;
        logic flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t STG_ADVANCE = '{en: 1'b1, flush: 1'b0};
    localparam stage_ctrl_t STG_BUBBLE  = '{en: 1'b1, flush: 1'b1};
    localparam stage_ctrl_t STG_HOLD    = '{en: 1'b0, flush: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// rtl/pipeline_hazard_ctrl_hazard_detect.sv - load-use hazard comparator
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    output logic                  load_use
);

    // A load into the zero register never produces a value worth waiting for.
    assign load_use = ex_memread && (ex_rt != ZERO_REG) &&
                      ((id_uses_rs && (id_rs == ex_rt)) ||
                       (id_uses_rt && (id_rt == ex_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - central stall/flush controller for the 5-stage pipeline
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_jump,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_branch_taken,
    input  logic                  ex_muldiv_start,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  ifid_flush,
    output logic                  idex_en,
    output logic                  idex_flush,
    output logic                  exmem_en,
    output logic                  exmem_flush,
    output logic                  memwb_en,
    output logic                  memwb_flush,
    output logic                  muldiv_busy,
    output logic                  muldiv_done,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
);

    localparam int CNT_BITS = ($clog2(MULDIV_LAT) > 3) ? $clog2(MULDIV_LAT) : 3;
    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(MULDIV_LAT - 1);

    ctrl_state_t         state, next_state;
    logic [CNT_BITS-1:0] cnt, next_cnt;
    stage_ctrl_t         ifid, idex, exmem, memwb;
    logic                load_use;
    logic                mem_wait;
    logic                flush_inc;

    hazard_detect u_hazard_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .load_use   (load_use)
    );

    assign mem_wait = mem_req && !mem_ready;

    always_comb begin
        pc_en       = 1'b1;
        ifid        = STG_ADVANCE;
        idex        = STG_ADVANCE;
        exmem       = STG_ADVANCE;
        memwb       = STG_ADVANCE;
        muldiv_busy = (state == MULDIV);
        muldiv_done = 1'b0;
        next_state  = state;
        next_cnt    = cnt;
        flush_inc   = 1'b0;

        if (!rst_n) begin
            pc_en       = 1'b0;
            ifid        = STG_BUBBLE;
            idex        = STG_BUBBLE;
            exmem       = STG_BUBBLE;
            memwb       = STG_BUBBLE;
            muldiv_busy = 1'b0;
        end else if (mem_wait) begin
            // Whole pipe freezes, but the mul/div unit keeps computing.
            pc_en = 1'b0;
            ifid  = STG_HOLD;
            idex  = STG_HOLD;
            exmem = STG_HOLD;
            memwb = STG_HOLD;
            if (cnt != '0)
                next_cnt = cnt - 1'b1;
        end else if (state == MULDIV) begin
            if (cnt != '0) begin
                pc_en    = 1'b0;
                ifid     = STG_HOLD;
                idex     = STG_HOLD;
                exmem    = STG_BUBBLE;
                next_cnt = cnt - 1'b1;
            end else begin
                muldiv_done = 1'b1;
                next_state  = RUN;
            end
        end else if (ex_branch_taken) begin
            ifid      = STG_BUBBLE;
            idex      = STG_BUBBLE;
            flush_inc = 1'b1;
        end else if (ex_muldiv_start) begin
            pc_en      = 1'b0;
            ifid       = STG_HOLD;
            idex       = STG_HOLD;
            exmem      = STG_BUBBLE;
            next_cnt   = CNT_LOAD;
            next_state = MULDIV;
        end else if (load_use) begin
            pc_en = 1'b0;
            ifid  = STG_HOLD;
            idex  = STG_BUBBLE;
        end else if (id_jump) begin
            ifid      = STG_BUBBLE;
            flush_inc = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= RUN;
            cnt          <= '0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (!pc_en)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (flush_inc)
                flush_events <= flush_events + CNT_W'(1);
        end
    end

    assign ifid_en     = ifid.en;
    assign ifid_flush  = ifid.flush;
    assign idex_en     = idex.en;
    assign idex_flush  = idex.flush;
    assign exmem_en    = exmem.en;
    assign exmem_flush = exmem.flush;
    assign memwb_en    = memwb.en;
    assign memwb_flush = memwb.flush;

endmodule
